// File: rtl/alu_uart_interface_pkg.sv
// Shared widths and ALU opcode encodings for the ALU/UART responder and its neighbours.
//   NB_DATA : width of operands, result and UART bytes
//   NB_OP   : width of the ALU opcode (low bits of the OP byte)
//   OP_*    : opcode values understood by the combinational alu
package alu_uart_interface_pkg;

  localparam int unsigned NB_DATA = 8;
  localparam int unsigned NB_OP   = 6;

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_uart_interface.sv
// Responder between uart_rx/uart_tx and the combinational alu.
// Collects A, B, OP bytes from uart_rx, presents them to the alu, then hands
// the alu result to uart_tx and waits for it to finish.
//   i_clock, i_reset_n : clock and asynchronous active-low reset
//   i_rx_data/i_rx_done: received byte and its one-cycle strobe
//   i_tx_done          : uart_tx finished the current byte
//   i_alu_result       : combinational alu result
//   o_alu_a/b/op       : registered alu operands and opcode
//   o_tx_data/o_tx_start: registered result byte and one-cycle start pulse
//   o_busy             : decode of EXEC/WAIT_TX
//   o_overrun          : sticky flag, a byte arrived while busy and was dropped
module alu_uart_interface
  import alu_uart_interface_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_overrun
);

  typedef enum logic [2:0] {
    ST_GET_A   = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_e;

  state_e             state_q,    state_d;
  logic [NB_DATA-1:0] alu_a_q,    alu_a_d;
  logic [NB_DATA-1:0] alu_b_q,    alu_b_d;
  logic [NB_OP-1:0]   alu_op_q,   alu_op_d;
  logic [NB_DATA-1:0] tx_data_q,  tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               overrun_q,  overrun_d;

  // Next-state and register updates; everything holds unless a state acts on it.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = overrun_q;

    case (state_q)
      ST_GET_A: begin
        if (i_rx_done) begin
          alu_a_d = i_rx_data;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (i_rx_done) begin
          alu_b_d = i_rx_data;
          state_d = ST_GET_OP;
        end
      end
      ST_GET_OP: begin
        if (i_rx_done) begin
          alu_op_d = i_rx_data[NB_OP-1:0];
          state_d  = ST_EXEC;
        end
      end
      // Operands have been stable at the alu for a full cycle; capture result.
      ST_EXEC: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        if (i_rx_done) overrun_d = 1'b1;
        state_d = ST_WAIT_TX;
      end
      // A byte arriving together with tx_done is still dropped.
      ST_WAIT_TX: begin
        if (i_rx_done) overrun_d = 1'b1;
        if (i_tx_done) state_d = ST_GET_A;
      end
      default: state_d = ST_GET_A;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_GET_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_overrun  = overrun_q;
  assign o_busy     = (state_q == ST_EXEC) || (state_q == ST_WAIT_TX);

endmodule
